// File: rtl/hnmpp.sv
// hnmpp: Hit Nonzero Map, one occupancy bit per SSID with a one-cycle registered lookup.
// Define HNMPP_WR_BYPASS_EN to forward a same-cycle write into a read of the same SSID.

module hnmpp #(
    parameter int SSID_WIDTH = 8,
    parameter int NROWS_HNM  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SSID_WIDTH-1:0] SSID_write,
    input  logic                  write,
    input  logic [SSID_WIDTH-1:0] SSID_read,
    input  logic                  read,
    output logic                  HNM_writeReady,
    output logic                  HNM_readReady,
    output logic [SSID_WIDTH-1:0] HNM_SSID_read,
    output logic                  HNM_SSIDHit,
    output logic                  testResult
);

    logic [NROWS_HNM-1:0]  map_q, map_d;
    logic                  ready_q, ready_d;
    logic [SSID_WIDTH-1:0] ssid_read_q, ssid_read_d;
    logic                  hit_q, hit_d;
    logic                  test_q, test_d;
    logic                  wr_acc, rd_acc;

    always_comb begin
        wr_acc      = write && ready_q;
        rd_acc      = read && ready_q;
        ready_d     = 1'b1;
        map_d       = map_q;
        ssid_read_d = ssid_read_q;
        hit_d       = 1'b0;

        if (wr_acc) begin
            map_d[SSID_write] = 1'b1;
        end

        if (rd_acc) begin
            ssid_read_d = SSID_read;
`ifdef HNMPP_WR_BYPASS_EN
            // Write-first: the lookup sees this cycle's write.
            hit_d = map_d[SSID_read];
`else
            // Read-first: the lookup sees the map as it stood before this edge.
            hit_d = map_q[SSID_read];
`endif
        end

        test_d = |map_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            map_q       <= '0;
            ready_q     <= 1'b0;
            ssid_read_q <= '0;
            hit_q       <= 1'b0;
            test_q      <= 1'b0;
        end else begin
            map_q       <= map_d;
            ready_q     <= ready_d;
            ssid_read_q <= ssid_read_d;
            hit_q       <= hit_d;
            test_q      <= test_d;
        end
    end

    assign HNM_writeReady = ready_q;
    assign HNM_readReady  = ready_q;
    assign HNM_SSID_read  = ssid_read_q;
    assign HNM_SSIDHit    = hit_q;
    assign testResult     = test_q;

endmodule

// File: tb/tb_hnmpp.sv
// Testbench for hnmpp: directed scenarios plus random traffic against a behavioural occupancy model.
// Honours HNMPP_WR_BYPASS_EN the same way the design does.

module tb_hnmpp;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] SSID_write = '0;
    logic       write = 1'b0;
    logic [7:0] SSID_read = '0;
    logic       read = 1'b0;
    logic       HNM_writeReady, HNM_readReady;
    logic [7:0] HNM_SSID_read;
    logic       HNM_SSIDHit, testResult;

`ifdef HNMPP_WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    hnmpp #(.SSID_WIDTH(8), .NROWS_HNM(256)) dut (
        .clk(clk), .reset(reset),
        .SSID_write(SSID_write), .write(write),
        .SSID_read(SSID_read), .read(read),
        .HNM_writeReady(HNM_writeReady), .HNM_readReady(HNM_readReady),
        .HNM_SSID_read(HNM_SSID_read), .HNM_SSIDHit(HNM_SSIDHit),
        .testResult(testResult)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: a set of marked SSIDs plus the expected output values.
    bit       mdl_map [256];
    logic [7:0] mdl_ssid;
    logic     mdl_hit, mdl_test, mdl_rdy;

    task automatic model_clear();
        foreach (mdl_map[i]) mdl_map[i] = 1'b0;
        mdl_ssid = '0; mdl_hit = 1'b0; mdl_test = 1'b0; mdl_rdy = 1'b0;
    endtask

    // Drive one clock's worth of strobes (called just after an edge), advance, update the model.
    task automatic drive_cycle(input bit w, input logic [7:0] ws, input bit r, input logic [7:0] rs);
        bit acc_w, acc_r;
        write = w; SSID_write = ws; read = r; SSID_read = rs;
        acc_w = w && mdl_rdy;
        acc_r = r && mdl_rdy;
        if (acc_r) begin
            mdl_ssid = rs;
            mdl_hit  = mdl_map[rs] || (BYPASS && acc_w && ws == rs);
        end else begin
            mdl_hit = 1'b0;
        end
        if (acc_w) begin
            mdl_map[ws] = 1'b1;
            mdl_test = 1'b1;
        end
        mdl_rdy = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0; read = 1'b0;
    endtask

    // Asserts reset mid-cycle and releases it before the next edge; readies stay low until that edge.
    task automatic pulse_reset();
        reset = 1'b1;
        model_clear();
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        pulse_reset();
        n_checks++;
        if ({HNM_writeReady, HNM_readReady, HNM_SSID_read, HNM_SSIDHit, testResult} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_values: wr_rdy=%b rd_rdy=%b ssid=%h hit=%b test=%b, expected all 0",
                     HNM_writeReady, HNM_readReady, HNM_SSID_read, HNM_SSIDHit, testResult);
        end
        // Strobes while the readies are still low must be ignored.
        drive_cycle(1, 8'h33, 1, 8'h33);
        n_checks++;
        if (HNM_writeReady !== 1'b1 || HNM_readReady !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_rise: wr_rdy=%b rd_rdy=%b, expected 1 1", HNM_writeReady, HNM_readReady);
        end
        n_checks++;
        if (HNM_SSID_read !== 8'h00 || HNM_SSIDHit !== 1'b0 || testResult !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_strobes: ssid=%h hit=%b test=%b, expected 00 0 0",
                     HNM_SSID_read, HNM_SSIDHit, testResult);
        end
        drive_cycle(0, 0, 1, 8'h33);
        n_checks++;
        if (HNM_SSIDHit !== 1'b0 || HNM_SSID_read !== 8'h33) begin
            n_fail++;
            $display("FAIL ignored_write_read: hit=%b ssid=%h, expected 0 33", HNM_SSIDHit, HNM_SSID_read);
        end
    endtask

    task automatic test_sweep();
        pulse_reset();
        drive_cycle(0, 0, 0, 0);
        for (int i = 0; i < 256; i++) begin
            drive_cycle(0, 0, 1, i[7:0]);
            n_checks++;
            if (HNM_SSIDHit !== 1'b0 || HNM_SSID_read !== i[7:0] || testResult !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep[%0d]: hit=%b ssid=%h test=%b, expected 0 %h 0",
                         i, HNM_SSIDHit, HNM_SSID_read, testResult, i[7:0]);
            end
        end
        drive_cycle(0, 0, 0, 0);
        n_checks++;
        if (HNM_SSIDHit !== 1'b0 || HNM_SSID_read !== 8'hFF) begin
            n_fail++;
            $display("FAIL idle_hold: hit=%b ssid=%h, expected 0 ff", HNM_SSIDHit, HNM_SSID_read);
        end
    endtask

    task automatic test_write_read();
        drive_cycle(1, 8'h05, 0, 0);
        n_checks++;
        if (testResult !== 1'b1) begin
            n_fail++;
            $display("FAIL test_after_write: test=%b, expected 1", testResult);
        end
        drive_cycle(0, 0, 1, 8'h05);
        n_checks++;
        if (HNM_SSIDHit !== 1'b1 || HNM_SSID_read !== 8'h05) begin
            n_fail++;
            $display("FAIL read_05: hit=%b ssid=%h, expected 1 05", HNM_SSIDHit, HNM_SSID_read);
        end
        drive_cycle(0, 0, 1, 8'h06);
        n_checks++;
        if (HNM_SSIDHit !== 1'b0 || HNM_SSID_read !== 8'h06 || testResult !== 1'b1) begin
            n_fail++;
            $display("FAIL read_06: hit=%b ssid=%h test=%b, expected 0 06 1",
                     HNM_SSIDHit, HNM_SSID_read, testResult);
        end
    endtask

    task automatic test_boundary();
        logic [7:0] addrs [3];
        logic       exp [3];
        addrs[0] = 8'h00; addrs[1] = 8'hFF; addrs[2] = 8'h80;
        exp[0] = 1'b1; exp[1] = 1'b1; exp[2] = 1'b0;
        drive_cycle(1, 8'h00, 0, 0);
        drive_cycle(1, 8'hFF, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 0, 1, addrs[i]);
            n_checks++;
            if (HNM_SSIDHit !== exp[i] || HNM_SSID_read !== addrs[i]) begin
                n_fail++;
                $display("FAIL boundary_%h: hit=%b ssid=%h, expected %b %h",
                         addrs[i], HNM_SSIDHit, HNM_SSID_read, exp[i], addrs[i]);
            end
        end
    endtask

    task automatic test_same_cycle();
        pulse_reset();
        drive_cycle(0, 0, 0, 0);
        drive_cycle(1, 8'h42, 1, 8'h42);
        n_checks++;
        if (HNM_SSIDHit !== BYPASS || HNM_SSID_read !== 8'h42) begin
            n_fail++;
            $display("FAIL same_cycle_42: hit=%b ssid=%h, expected %b 42", HNM_SSIDHit, HNM_SSID_read, BYPASS);
        end
        drive_cycle(0, 0, 1, 8'h42);
        n_checks++;
        if (HNM_SSIDHit !== 1'b1) begin
            n_fail++;
            $display("FAIL repeat_42: hit=%b, expected 1", HNM_SSIDHit);
        end
        // Write and read of different SSIDs in one cycle both take effect.
        drive_cycle(1, 8'h43, 1, 8'h42);
        drive_cycle(0, 0, 1, 8'h43);
        n_checks++;
        if (HNM_SSIDHit !== 1'b1 || HNM_SSID_read !== 8'h43) begin
            n_fail++;
            $display("FAIL diff_ssid_43: hit=%b ssid=%h, expected 1 43", HNM_SSIDHit, HNM_SSID_read);
        end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1, 8'h10, 1, 8'h42);
        n_checks++;
        if (testResult !== 1'b1 || HNM_SSIDHit !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: test=%b hit=%b, expected 1 1", testResult, HNM_SSIDHit);
        end
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        n_checks++;
        if ({HNM_writeReady, HNM_readReady, HNM_SSID_read, HNM_SSIDHit, testResult} !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset: wr_rdy=%b rd_rdy=%b ssid=%h hit=%b test=%b, expected all 0",
                     HNM_writeReady, HNM_readReady, HNM_SSID_read, HNM_SSIDHit, testResult);
        end
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        mdl_rdy = 1'b1;
        drive_cycle(0, 0, 1, 8'h10);
        n_checks++;
        if (HNM_SSIDHit !== 1'b0 || HNM_SSID_read !== 8'h10 || testResult !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_10: hit=%b ssid=%h test=%b, expected 0 10 0",
                     HNM_SSIDHit, HNM_SSID_read, testResult);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) drive_cycle(1, 8'h20, 0, 0);
        for (int i = 0; i < 2; i++) begin
            drive_cycle(0, 0, 1, 8'h20);
            n_checks++;
            if (HNM_SSIDHit !== 1'b1 || HNM_SSID_read !== 8'h20 || testResult !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_read%0d: hit=%b ssid=%h test=%b, expected 1 20 1",
                         i, HNM_SSIDHit, HNM_SSID_read, testResult);
            end
        end
    endtask

    task automatic test_random();
        bit w, r;
        logic [7:0] ws, rs;
        pulse_reset();
        drive_cycle(0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            w  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 1) == 0);
            ws = 8'($urandom_range(0, 15));
            rs = ($urandom_range(0, 3) == 0) ? ws : 8'($urandom_range(0, 15));
            drive_cycle(w, ws, r, rs);
            n_checks++;
            if (HNM_SSIDHit !== mdl_hit || HNM_SSID_read !== mdl_ssid || testResult !== mdl_test
                || HNM_readReady !== mdl_rdy) begin
                n_fail++;
                $display("FAIL random[%0d]: hit=%b ssid=%h test=%b rdy=%b, expected %b %h %b %b",
                         i, HNM_SSIDHit, HNM_SSID_read, testResult, HNM_readReady,
                         mdl_hit, mdl_ssid, mdl_test, mdl_rdy);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_sweep();
        test_write_read();
        test_boundary();
        test_same_cycle();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end

endmodule
